cam_pass_ctrl: RTL and testbench
================================

Name: cam_pass_ctrl

Overview:
- Drives a bank of NUM_CELLS CAM cells that share a broadcast bus and have one write enable per cell.
- Each accepted command runs one associative pass: a masked compare at a word address, then a tag latch, then an optional masked write to every tagged cell.
- Returns a match count and the tag vector to the upstream sequencer through a valid/ready command handshake.

Parameters:
- NUM_CELLS, 8, number of CAM cells driven; width of match_vec, wea_vec and tags.
- RAM_WIDTH, 8, word width of each cell.
- RAM_ADDR_BITS, 1, width of the cell word address.

Ports:
- clka  in  1  clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_addr  in  RAM_ADDR_BITS  word address for the pass.
- cmd_key  in  RAM_WIDTH  compare key.
- cmd_cmask  in  RAM_WIDTH  compare mask.
- cmd_data  in  RAM_WIDTH  write value.
- cmd_wmask  in  RAM_WIDTH  write mask.
- cmd_write  in  1  1 runs the write phase; 0 is search only.
- addr  out  RAM_ADDR_BITS  broadcast word address to the cells.
- masked_key  out  RAM_WIDTH  broadcast key & cmask.
- masked_dina  out  RAM_WIDTH  broadcast data & wmask.
- mask  out  RAM_WIDTH  broadcast mask: cmask in COMPARE, wmask in WRITE, 0 otherwise.
- wea_vec  out  NUM_CELLS  per-cell write enable.
- match_vec  in  NUM_CELLS  combinational match outputs from the cells.
- done  out  1  one-cycle pulse when a pass completes.
- match_count  out  $clog2(NUM_CELLS+1)  number of tagged cells, valid while done=1.
- tags  out  NUM_CELLS  latched tag vector, held until the next COMPARE.

Behaviour:
- FSM states: IDLE, COMPARE, WRITE, DONE.
- Reset values: state=IDLE, cmd_ready=1, addr=0, masked_key=0, masked_dina=0, mask=0, wea_vec=0, done=0, match_count=0, tags=0.
- IDLE: cmd_ready=1.
  - When cmd_valid & cmd_ready, register all command fields and go to COMPARE.
  - cmd_ready is 0 in every other state; commands offered then are not consumed.
- COMPARE (1 cycle):
  - Drive addr=cmd_addr, mask=cmd_cmask, masked_key=cmd_key&cmd_cmask, wea_vec=0.
  - At the end of the cycle, latch tags<=match_vec and match_count<=popcount(match_vec).
  - Next state: WRITE if cmd_write=1, else DONE.
- WRITE (1 cycle):
  - Drive addr=cmd_addr, mask=cmd_wmask, masked_dina=cmd_data&cmd_wmask, wea_vec=tags.
  - wea_vec is nonzero only in this state.
  - Next state: DONE.
- DONE (1 cycle): done=1, mask=0, wea_vec=0, then return to IDLE.
- Latency, measured from the accept edge:
  - done is high in the 3rd cycle after accept with cmd_write=1.
  - done is high in the 2nd cycle after accept with cmd_write=0.
  - The next command is accepted in the cycle after done; back-to-back throughput is one pass per 4 cycles (write) or 3 cycles (search only).
- Zero matches: WRITE still occurs with wea_vec=0; match_count=0.
- All cells match: match_count=NUM_CELLS; no overflow, because the width covers NUM_CELLS.
- cmd_cmask=0: every cell matches (all-ones tags).
- cmd_wmask=0 with write: masked_dina=0 and mask=0, so the cells hold their contents.
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - An in-flight WRITE is abandoned; wea_vec=0 from the following cycle.
  - No done pulse is produced for the aborted pass.
- Command fields are sampled only at accept; later changes on cmd_* have no effect on the pass in progress.

Optional Feature:
- Macro: CAM_PRIORITY_WRITE_EN.
- Defined:
  - In WRITE, wea_vec carries only the lowest-index set bit of tags (single-responder write).
  - tags and match_count still report all matches.
- Undefined: wea_vec=tags (multi-responder write).

Test Plan:
- Reset, then NUM_CELLS=8 with cell words {0x00..0x07} at addr 0. Command key=0x05, cmask=0xFF, write=0 -> done 2 cycles after accept, tags=8'b0010_0000, match_count=1, wea_vec never nonzero.
- Same cells, key=0x01, cmask=0x01, data=0xA0, wmask=0xF0, write=1 -> tags=8'b1010_1010, match_count=4. WRITE cycle shows wea_vec=0xAA, masked_dina=0xA0, mask=0xF0. Odd cells then read 0xA1, 0xA3, 0xA5, 0xA7; even cells are unchanged.
- cmask=0x00 -> match_count=8, tags=0xFF. Key=0x55 with cmask=0xFF on those cells -> match_count=0, wea_vec stays 0 in WRITE.
- Hold cmd_valid=1 continuously with write=1 -> accepts occur every 4 cycles, cmd_ready=0 outside IDLE, exactly one done pulse per accept.
- Assert rst during the WRITE cycle -> next cycle wea_vec=0, state=IDLE, cmd_ready=1, no done pulse.
- With CAM_PRIORITY_WRITE_EN defined and tags=8'b1010_1010 -> wea_vec=8'b0000_0010 in WRITE, match_count=4.

Source files
------------

// File: rtl/cam_pass_ctrl.sv
// Associative-pass sequencer for a bank of CAM cells: masked compare, tag latch, tagged write.
// Build option CAM_PRIORITY_WRITE_EN restricts the write to the lowest-index tagged cell.
module cam_pass_ctrl #(
   parameter int unsigned NUM_CELLS     = 8,
   parameter int unsigned RAM_WIDTH     = 8,
   parameter int unsigned RAM_ADDR_BITS = 1
) (
   input  logic                             clka,
   input  logic                             rst,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic [RAM_ADDR_BITS-1:0]         cmd_addr,
   input  logic [RAM_WIDTH-1:0]             cmd_key,
   input  logic [RAM_WIDTH-1:0]             cmd_cmask,
   input  logic [RAM_WIDTH-1:0]             cmd_data,
   input  logic [RAM_WIDTH-1:0]             cmd_wmask,
   input  logic                             cmd_write,
   output logic [RAM_ADDR_BITS-1:0]         addr,
   output logic [RAM_WIDTH-1:0]             masked_key,
   output logic [RAM_WIDTH-1:0]             masked_dina,
   output logic [RAM_WIDTH-1:0]             mask,
   output logic [NUM_CELLS-1:0]             wea_vec,
   input  logic [NUM_CELLS-1:0]             match_vec,
   output logic                             done,
   output logic [$clog2(NUM_CELLS+1)-1:0]   match_count,
   output logic [NUM_CELLS-1:0]             tags
);

   localparam int unsigned CntW = $clog2(NUM_CELLS + 1);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCompare = 2'd1;
   localparam logic [1:0] StWrite   = 2'd2;
   localparam logic [1:0] StDone    = 2'd3;

   logic [1:0]               state_q, state_d;
   logic [RAM_ADDR_BITS-1:0] addr_q;
   logic [RAM_WIDTH-1:0]     key_q;
   logic [RAM_WIDTH-1:0]     cmask_q;
   logic [RAM_WIDTH-1:0]     data_q;
   logic [RAM_WIDTH-1:0]     wmask_q;
   logic                     write_q;
   logic [NUM_CELLS-1:0]     tags_q;
   logic [CntW-1:0]          count_q;

   logic                     accept;
   logic [CntW-1:0]          popcnt;
   logic [NUM_CELLS-1:0]     wr_sel;

   assign accept = cmd_valid && (state_q == StIdle);

   always_comb begin
      popcnt = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         popcnt = popcnt + CntW'(match_vec[i]);
      end
   end

`ifdef CAM_PRIORITY_WRITE_EN
   // Two's-complement trick isolates the lowest set tag bit.
   assign wr_sel = tags_q & (~tags_q + {{(NUM_CELLS-1){1'b0}}, 1'b1});
`else
   assign wr_sel = tags_q;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (cmd_valid) state_d = StCompare;
         StCompare: state_d = write_q ? StWrite : StDone;
         StWrite:   state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clka) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         key_q   <= '0;
         cmask_q <= '0;
         data_q  <= '0;
         wmask_q <= '0;
         write_q <= 1'b0;
         tags_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= cmd_addr;
            key_q   <= cmd_key;
            cmask_q <= cmd_cmask;
            data_q  <= cmd_data;
            wmask_q <= cmd_wmask;
            write_q <= cmd_write;
         end
         if (state_q == StCompare) begin
            tags_q  <= match_vec;
            count_q <= popcnt;
         end
      end
   end

   // Broadcast values are held from the captured command; mask alone gates what the cells use.
   always_comb begin
      mask    = '0;
      wea_vec = '0;
      unique case (state_q)
         StCompare: mask = cmask_q;
         StWrite: begin
            mask    = wmask_q;
            wea_vec = wr_sel;
         end
         default: begin
            mask    = '0;
            wea_vec = '0;
         end
      endcase
   end

   assign cmd_ready   = (state_q == StIdle);
   assign addr        = addr_q;
   assign masked_key  = key_q & cmask_q;
   assign masked_dina = data_q & wmask_q;
   assign done        = (state_q == StDone);
   assign match_count = count_q;
   assign tags        = tags_q;

endmodule

// File: tb/tb_cam_pass_ctrl.sv
// Scoreboard bench for cam_pass_ctrl with a behavioural 8-cell, 2-word CAM bank.
module tb_cam_pass_ctrl;

   logic       clka = 1'b0;
   logic       rst  = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [0:0] cmd_addr  = '0;
   logic [7:0] cmd_key   = '0;
   logic [7:0] cmd_cmask = '0;
   logic [7:0] cmd_data  = '0;
   logic [7:0] cmd_wmask = '0;
   logic       cmd_write = 1'b0;
   logic [0:0] addr;
   logic [7:0] masked_key, masked_dina, mask, wea_vec, match_vec, tags;
   logic       done;
   logic [3:0] match_count;

   cam_pass_ctrl #(
      .NUM_CELLS     (8),
      .RAM_WIDTH     (8),
      .RAM_ADDR_BITS (1)
   ) dut (
      .clka        (clka),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_key     (cmd_key),
      .cmd_cmask   (cmd_cmask),
      .cmd_data    (cmd_data),
      .cmd_wmask   (cmd_wmask),
      .cmd_write   (cmd_write),
      .addr        (addr),
      .masked_key  (masked_key),
      .masked_dina (masked_dina),
      .mask        (mask),
      .wea_vec     (wea_vec),
      .match_vec   (match_vec),
      .done        (done),
      .match_count (match_count),
      .tags        (tags)
   );

   always #5 clka = ~clka;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Behavioural CAM bank: addr 0 holds i, addr 1 holds 0xF0|i; reloaded on reset.
   logic [7:0] cells [8][2];

   always @(posedge clka) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            cells[i][0] <= 8'(i);
            cells[i][1] <= 8'hF0 | 8'(i);
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wea_vec[i]) cells[i][addr] <= (cells[i][addr] & ~mask) | masked_dina;
         end
      end
   end

   always_comb begin
      match_vec = '0;
      for (int i = 0; i < 8; i++) begin
         match_vec[i] = (((cells[i][addr] ^ masked_key) & mask) == 8'h00);
      end
   end

   int   cyc = 0;
   logic rst_q = 1'b1;
   always @(posedge clka) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   typedef struct {
      int         acc;
      logic       wr;
      logic [0:0] a;
      logic [7:0] key, cmask, data, wmask, tags, wea;
      int         cnt;
   } pass_t;

   pass_t      q[$];
   pass_t      e;
   logic [7:0] t;
   logic [7:0] last_wea = '0;
   logic       b2b = 1'b0;
   logic       have_prev = 1'b0;
   int         prev_acc = 0;
   int         n_acc = 0;
   int         n_done = 0;

   always @(negedge clka) begin
      if (rst_q) begin
         check("rst_ready", cmd_ready, 1);
         check("rst_wea", wea_vec, 0);
         check("rst_done", done, 0);
         check("rst_mask", mask, 0);
         q.delete();
      end else begin
         if (q.size() != 0 && cyc == q[0].acc) begin
            check("cmp_mask", mask, q[0].cmask);
            check("cmp_key", masked_key, q[0].key & q[0].cmask);
            check("cmp_addr", addr, q[0].a);
            check("cmp_wea", wea_vec, 0);
            check("cmp_ready", cmd_ready, 0);
         end else if (q.size() != 0 && q[0].wr && cyc == q[0].acc + 1) begin
            check("wr_wea", wea_vec, q[0].wea);
            check("wr_dina", masked_dina, q[0].data & q[0].wmask);
            check("wr_mask", mask, q[0].wmask);
            check("wr_ready", cmd_ready, 0);
            check("wr_done", done, 0);
            last_wea = wea_vec;
         end else if (done) begin
            if (q.size() == 0) begin
               check("spurious_done", done, 0);
            end else begin
               check("done_latency", cyc - q[0].acc, q[0].wr ? 2 : 1);
               check("done_tags", tags, q[0].tags);
               check("done_count", match_count, q[0].cnt);
               check("done_wea", wea_vec, 0);
               check("done_mask", mask, 0);
               check("done_ready", cmd_ready, 0);
               void'(q.pop_front());
               n_done++;
            end
         end else begin
            check("idle_wea", wea_vec, 0);
            if (q.size() != 0 && cyc > q[0].acc + 2) begin
               check("done_timeout", 0, 1);
               void'(q.pop_front());
            end
         end
         if (cmd_valid && cmd_ready && !rst) begin
            t = '0;
            e.cnt = 0;
            for (int i = 0; i < 8; i++) begin
               t[i] = (((cells[i][cmd_addr] ^ cmd_key) & cmd_cmask) == 8'h00);
               if (t[i]) e.cnt++;
            end
            e.acc   = cyc + 1;
            e.wr    = cmd_write;
            e.a     = cmd_addr;
            e.key   = cmd_key;
            e.cmask = cmd_cmask;
            e.data  = cmd_data;
            e.wmask = cmd_wmask;
            e.tags  = t;
`ifdef CAM_PRIORITY_WRITE_EN
            e.wea   = t & (~t + 8'd1);
`else
            e.wea   = t;
`endif
            q.push_back(e);
            if (b2b && have_prev) check("b2b_gap", e.acc - prev_acc, 4);
            prev_acc  = e.acc;
            have_prev = 1'b1;
            n_acc++;
         end
      end
   end

   // Entered and left at posedge+1; fields are scrambled after accept to prove they were captured.
   task automatic run_cmd(input logic [0:0] a, input logic [7:0] key, input logic [7:0] cm,
                          input logic [7:0] d, input logic [7:0] wm, input logic w);
      int guard = 0;
      while (!cmd_ready && guard < 20) begin
         @(posedge clka); #1;
         guard++;
      end
      check("ready_timeout", cmd_ready, 1);
      cmd_addr  = a;
      cmd_key   = key;
      cmd_cmask = cm;
      cmd_data  = d;
      cmd_wmask = wm;
      cmd_write = w;
      cmd_valid = 1'b1;
      @(posedge clka); #1;
      cmd_valid = 1'b0;
      cmd_addr  = 1'($urandom);
      cmd_key   = 8'($urandom);
      cmd_cmask = 8'($urandom);
      cmd_data  = 8'($urandom);
      cmd_wmask = 8'($urandom);
      cmd_write = 1'($urandom);
      guard = 0;
      while (q.size() != 0 && guard < 10) begin
         @(posedge clka); #1;
         guard++;
      end
      check("pass_drain", q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc0, done0;
      repeat (2) @(posedge clka);
      #1;
      check("reset_ready", cmd_ready, 1);
      check("reset_addr", addr, 0);
      check("reset_key", masked_key, 0);
      check("reset_dina", masked_dina, 0);
      check("reset_count", match_count, 0);
      check("reset_tags", tags, 0);
      rst = 1'b0;
      @(posedge clka); #1;

      // Exact search, single responder.
      run_cmd(1'b0, 8'h05, 8'hFF, 8'h00, 8'h00, 1'b0);
      check("srch_tags", tags, 8'h20);
      check("srch_last_wea", last_wea, 0);

      // Odd-cell search with masked write of the high nibble.
      run_cmd(1'b0, 8'h01, 8'h01, 8'hA0, 8'hF0, 1'b1);
      check("odd_tags", tags, 8'hAA);
`ifdef CAM_PRIORITY_WRITE_EN
      check("odd_wea", last_wea, 8'h02);
      check("cell1", cells[1][0], 8'hA1);
      check("cell3", cells[3][0], 8'h03);
`else
      check("odd_wea", last_wea, 8'hAA);
      check("cell1", cells[1][0], 8'hA1);
      check("cell3", cells[3][0], 8'hA3);
      check("cell7", cells[7][0], 8'hA7);
`endif
      check("cell2", cells[2][0], 8'h02);
      check("cell1_hi", cells[1][1], 8'hF1);

      // Zero compare mask matches everything; zero write mask leaves the cells alone.
      run_cmd(1'b0, 8'h3C, 8'h00, 8'hFF, 8'h00, 1'b1);
      check("all_tags", tags, 8'hFF);
      check("all_cell0", cells[0][0], 8'h00);
      check("all_cell1", cells[1][0], 8'hA1);

      // No responders: write phase still runs with no enables.
      run_cmd(1'b0, 8'h55, 8'hFF, 8'h12, 8'hFF, 1'b1);
      check("none_tags", tags, 8'h00);
      check("none_wea", last_wea, 8'h00);

      // Other word address.
      run_cmd(1'b1, 8'hF3, 8'hFF, 8'h00, 8'h00, 1'b0);
      check("addr1_tags", tags, 8'h08);

      // Back-to-back writes with cmd_valid held high.
      acc0  = n_acc;
      done0 = n_done;
      b2b       = 1'b1;
      have_prev = 1'b0;
      cmd_addr  = 1'b0;
      cmd_key   = 8'h00;
      cmd_cmask = 8'h00;
      cmd_data  = 8'h00;
      cmd_wmask = 8'h00;
      cmd_write = 1'b1;
      cmd_valid = 1'b1;
      repeat (16) @(posedge clka);
      #1;
      cmd_valid = 1'b0;
      b2b       = 1'b0;
      repeat (6) @(posedge clka);
      #1;
      check("b2b_accepts", n_acc - acc0, 4);
      check("b2b_dones", n_done - done0, n_acc - acc0);

      // Reset during the write cycle abandons the pass.
      cmd_addr  = 1'b0;
      cmd_key   = 8'h01;
      cmd_cmask = 8'h01;
      cmd_data  = 8'hC0;
      cmd_wmask = 8'hF0;
      cmd_write = 1'b1;
      cmd_valid = 1'b1;
      @(posedge clka); #1;
      cmd_valid = 1'b0;
      @(posedge clka); #1;
      check("pre_rst_wea", wea_vec, 0 + (wea_vec != 0 ? wea_vec : 8'hFF));
      rst = 1'b1;
      @(posedge clka); #1;
      rst = 1'b0;
      check("abort_wea", wea_vec, 0);
      check("abort_ready", cmd_ready, 1);
      check("abort_done", done, 0);
      check("abort_tags", tags, 0);
      done0 = n_done;
      repeat (5) @(posedge clka);
      #1;
      check("abort_no_done", n_done - done0, 0);

      // Recovery after abort.
      run_cmd(1'b0, 8'h05, 8'hFF, 8'h00, 8'h00, 1'b0);
      check("recover_tags", tags, 8'h20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
